// File: rtl/mbus_pkg.sv
// Shared types and widths for the page-decoded master bus interconnect.
package mbus_pkg;

    localparam int PAGE_W = 4;
    localparam int WAIT_W = 4;
    localparam int TMO_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

endpackage

// File: rtl/mbus_page_decoder.sv
// Combinational page decoder: address page field to one-hot slave hit.
module mbus_page_decoder
    import mbus_pkg::*;
#(
    parameter int                        NSLAVE     = 4,
    parameter logic [NSLAVE*PAGE_W-1:0]  SLAVE_PAGE = {NSLAVE{4'h0}}
) (
    input  logic [PAGE_W-1:0] page_i,
    output logic [NSLAVE-1:0] hit_o,
    output logic              valid_o
);

    logic [NSLAVE-1:0] match_s;

    // Raw page compare per slave, then keep only the lowest-index match.
    always_comb begin
        for (int i = 0; i < NSLAVE; i++) begin
            match_s[i] = (page_i == SLAVE_PAGE[i*PAGE_W +: PAGE_W]);
        end
        hit_o   = match_s & ~(match_s - {{(NSLAVE-1){1'b0}}, 1'b1});
        valid_o = |match_s;
    end

endmodule

// File: rtl/mbus_interconnect.sv
// Single-master to NSLAVE-slave interconnect with page decode, fixed wait
// states, slave handshake and access timeout.
module mbus_interconnect
    import mbus_pkg::*;
#(
    parameter int                        WIDTH       = 32,
    parameter int                        NSLAVE      = 4,
    parameter int                        SEL_LSB     = 12,
    parameter logic [NSLAVE*PAGE_W-1:0]  SLAVE_PAGE  = {4'hF, 4'hE, 4'hD, 4'h0},
    parameter logic [NSLAVE*WAIT_W-1:0]  WAIT_STATES = {(NSLAVE*WAIT_W){1'b0}},
    parameter int                        TIMEOUT     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_req,
    input  logic [WIDTH-1:0]        m_addr,
    input  logic [WIDTH-1:0]        m_wdata,
    input  logic                    m_wen,
    output logic [WIDTH-1:0]        m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic                    busy,
    output logic [NSLAVE-1:0]       s_cs,
    output logic [WIDTH-1:0]        s_addr,
    output logic [WIDTH-1:0]        s_wdata,
    output logic                    s_wen,
    input  logic [NSLAVE*WIDTH-1:0] s_rdata,
    input  logic [NSLAVE-1:0]       s_ack
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               wen_q, wen_d;
    logic [NSLAVE-1:0]  sel_q, sel_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic [NSLAVE-1:0]  hit_s;
    logic               valid_s;
    logic [WAIT_W-1:0]  ws_sel_s;
    logic [WIDTH-1:0]   rdata_sel_s;
    logic               complete_s;

    mbus_page_decoder #(
        .NSLAVE     (NSLAVE),
        .SLAVE_PAGE (SLAVE_PAGE)
    ) u_dec (
        .page_i  (m_addr[SEL_LSB +: PAGE_W]),
        .hit_o   (hit_s),
        .valid_o (valid_s)
    );

    // Wait count for the decoded slave and read data of the latched slave.
    always_comb begin
        ws_sel_s    = {WAIT_W{1'b0}};
        rdata_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < NSLAVE; i++) begin
            ws_sel_s    = ws_sel_s | (hit_s[i] ? WAIT_STATES[i*WAIT_W +: WAIT_W] : {WAIT_W{1'b0}});
            rdata_sel_s = rdata_sel_s | (sel_q[i] ? s_rdata[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
        end
        complete_s = (wait_q == {WAIT_W{1'b0}}) && ((s_ack & sel_q) != {NSLAVE{1'b0}});
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= {WIDTH{1'b0}};
            wdata_q <= {WIDTH{1'b0}};
            wen_q   <= 1'b0;
            sel_q   <= {NSLAVE{1'b0}};
            wait_q  <= {WAIT_W{1'b0}};
            tmo_q   <= {TMO_W{1'b0}};
            rdata_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wen_d   = m_wen;
                    sel_d   = hit_s;
                    wait_d  = ws_sel_s;
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = valid_s ? ST_ACCESS : ST_ERR;
                    // A failed read must present zero data in the ERR cycle.
                    rdata_d = (!valid_s && !m_wen) ? {WIDTH{1'b0}} : rdata_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                wait_d = (wait_q != {WAIT_W{1'b0}}) ? (wait_q - {{(WAIT_W-1){1'b0}}, 1'b1}) : wait_q;
                tmo_d  = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                if (complete_s) begin
                    state_d = ST_DONE;
                    rdata_d = wen_q ? rdata_q : rdata_sel_s;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    rdata_d = wen_q ? rdata_q : {WIDTH{1'b0}};
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        m_ready = 1'b0;
        m_err   = 1'b0;
        busy    = 1'b1;
        s_cs    = {NSLAVE{1'b0}};
        s_wen   = 1'b0;
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_ACCESS: begin
                s_cs  = sel_q;
                s_wen = wen_q & (|sel_q);
            end
            ST_DONE:   m_ready = 1'b1;
            ST_ERR: begin
                m_ready = 1'b1;
                m_err   = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

    assign m_rdata = rdata_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

endmodule

// File: tb/tb_mbus_interconnect.sv
// Self-checking bench: directed table, reset and back-to-back sequences,
// then random transfers against a transaction-level reference model.
module tb_mbus_interconnect;

    localparam int          W     = 32;
    localparam int          NS    = 4;
    localparam int          TMO   = 16;
    localparam logic [15:0] PAGES = 16'hFED0;
    localparam logic [15:0] WS    = 16'h0230;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            m_req = 1'b0;
    logic [W-1:0]    m_addr = 32'h0;
    logic [W-1:0]    m_wdata = 32'h0;
    logic            m_wen = 1'b0;
    logic [W-1:0]    m_rdata;
    logic            m_ready, m_err, busy, s_wen;
    logic [NS-1:0]   s_cs;
    logic [W-1:0]    s_addr, s_wdata;
    logic [NS*W-1:0] s_rdata = '0;
    logic [NS-1:0]   s_ack = 4'hF;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] model_rd;

    mbus_interconnect #(
        .WIDTH(W), .NSLAVE(NS), .SEL_LSB(12), .SLAVE_PAGE(PAGES),
        .WAIT_STATES(WS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata),
        .m_ready(m_ready), .m_err(m_err), .busy(busy), .s_cs(s_cs),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        int          d;
        logic [31:0] sdata;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  cs;
    } vec_t;

    vec_t tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lowest slave whose page matches addr[15:12], or -1.
    function automatic int find_sel(input logic [31:0] a);
        logic [15:0] pg;
        int r;
        pg = PAGES;
        r = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (a[15:12] == pg[i*4 +: 4]) r = i;
        end
        return r;
    endfunction

    function automatic int ws_of(input int i);
        logic [15:0] w;
        w = WS;
        return int'(w[i*4 +: 4]);
    endfunction

    // Issue one transfer; the target slave acks from ACCESS cycle d+1 on.
    task automatic run_and_check(input string name, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic wen,
                                 input int d, input logic [31:0] sdata,
                                 input int exp_lat, input logic exp_err,
                                 input logic [31:0] exp_rd, input logic [3:0] exp_cs);
        int sel, lat;
        logic err, wen1, busy0, busy1;
        logic [31:0] rd, addr1, wd1;
        logic [3:0] cs1;
        sel = find_sel(addr);
        lat = 0; err = 1'b0; rd = 32'h0; cs1 = 4'h0; wen1 = 1'b0;
        addr1 = 32'h0; wd1 = 32'h0; busy1 = 1'b0;
        @(negedge clk);
        busy0 = busy;
        m_req = 1'b1; m_addr = addr; m_wdata = wdata; m_wen = wen;
        s_ack = 4'hF;
        for (int i = 0; i < NS; i++) s_rdata[i*W +: W] = ~sdata;
        if (sel >= 0) begin
            s_rdata[sel*W +: W] = sdata;
            s_ack[sel] = 1'b0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            m_req = 1'b0;
            if (cyc == 1) begin
                cs1 = s_cs; wen1 = s_wen; addr1 = s_addr; wd1 = s_wdata; busy1 = busy;
            end
            if (m_ready) begin
                lat = cyc; err = m_err; rd = m_rdata;
                break;
            end
            if (sel >= 0) s_ack[sel] = (cyc > d);
        end
        s_ack = 4'hF;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " m_err"}, {31'h0, err}, {31'h0, exp_err});
        check({name, " m_rdata"}, rd, exp_rd);
        check({name, " s_cs"}, {28'h0, cs1}, {28'h0, exp_cs});
        check({name, " s_wen"}, {31'h0, wen1}, {31'h0, wen & (exp_cs != 4'h0)});
        check({name, " s_addr"}, addr1, addr);
        check({name, " s_wdata"}, wd1, wdata);
        check({name, " busy idle"}, {31'h0, busy0}, 32'h0);
        check({name, " busy active"}, {31'h0, busy1}, 32'h1);
    endtask

    initial begin
        int sel, c, lat, d;
        logic err, wen;
        logic [31:0] rd, addr, sdata, wdata;
        logic [3:0] cs, pg4;
        logic [5:0] rv, bv;
        logic seen_ready;

        tab[0] = '{32'h0000_0010, 32'h0,  1'b0, 0,   32'hDEADBEEF, 2,  1'b0, 32'hDEADBEEF, 4'h1};
        tab[1] = '{32'h0000_F001, 32'h55, 1'b1, 0,   32'h11111111, 2,  1'b0, 32'hDEADBEEF, 4'h8};
        tab[2] = '{32'h0000_D000, 32'h0,  1'b0, 0,   32'h12345678, 5,  1'b0, 32'h12345678, 4'h2};
        tab[3] = '{32'h0000_7000, 32'h0,  1'b0, 0,   32'h00000099, 1,  1'b1, 32'h0,        4'h0};
        tab[4] = '{32'h0000_E000, 32'h0,  1'b0, 100, 32'h00000077, 17, 1'b1, 32'h0,        4'h4};
        tab[5] = '{32'h0000_E000, 32'h0,  1'b0, 1,   32'h0F0F0F0F, 4,  1'b0, 32'h0F0F0F0F, 4'h4};
        tab[6] = '{32'h0000_E000, 32'h0,  1'b0, 15,  32'hCAFEF00D, 17, 1'b0, 32'hCAFEF00D, 4'h4};
        tab[7] = '{32'h0000_7004, 32'hAA, 1'b1, 0,   32'h00000033, 1,  1'b1, 32'hCAFEF00D, 4'h0};

        // Reset state, held across clock edges.
        #12;
        check("reset outputs", {m_rdata, 28'h0, m_ready, m_err, busy, s_wen},
              {32'h0, 32'h0});
        check("reset s_cs", {28'h0, s_cs}, 32'h0);
        check("reset s_addr", s_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("tab%0d", i), tab[i].addr, tab[i].wdata, tab[i].wen,
                          tab[i].d, tab[i].sdata, tab[i].lat, tab[i].err, tab[i].rd, tab[i].cs);
        end

        // Reset in the middle of an access with the slave stalling.
        @(negedge clk);
        m_req = 1'b1; m_addr = 32'h0000_0010; m_wdata = 32'h1234; m_wen = 1'b0;
        s_ack = 4'hE;
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort outputs", {m_rdata, 28'h0, m_ready, m_err, busy, s_wen}, {32'h0, 32'h0});
        check("abort s_cs", {28'h0, s_cs}, 32'h0);
        check("abort s_addr", s_addr, 32'h0);
        check("abort s_wdata", s_wdata, 32'h0);
        seen_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen_ready = seen_ready | m_ready;
        end
        check("abort no ready", {31'h0, seen_ready}, 32'h0);
        reset = 1'b1;
        s_ack = 4'hF;
        run_and_check("post reset", 32'h0000_0020, 32'h0, 1'b0, 0, 32'h0BADF00D,
                      2, 1'b0, 32'h0BADF00D, 4'h1);

        // Request held high across DONE restarts at the next IDLE cycle.
        @(negedge clk);
        m_req = 1'b1; m_addr = 32'h0000_0010; m_wen = 1'b0;
        s_rdata[0 +: W] = 32'hA5A50001;
        rv = 6'h0; bv = 6'h0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            rv[cyc-1] = m_ready;
            bv[cyc-1] = busy;
            if (cyc == 6) m_req = 1'b0;
        end
        check("b2b ready", {26'h0, rv}, {26'h0, 6'b010010});
        check("b2b busy", {26'h0, bv}, {26'h0, 6'b011011});
        check("b2b rdata", m_rdata, 32'hA5A50001);
        model_rd = 32'hA5A50001;

        // Random transfers against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: pg4 = 4'h0;
                1: pg4 = 4'hD;
                2: pg4 = 4'hE;
                3: pg4 = 4'hF;
                default: pg4 = 4'($urandom_range(0, 15));
            endcase
            addr  = {16'($urandom), pg4, 12'($urandom)};
            wdata = $urandom;
            sdata = $urandom;
            wen   = 1'($urandom_range(0, 1));
            d     = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(0, 5));
            sel   = find_sel(addr);
            if (sel < 0) begin
                lat = 1; err = 1'b1; rd = wen ? model_rd : 32'h0; cs = 4'h0;
            end else begin
                c  = (ws_of(sel) > d) ? ws_of(sel) + 1 : d + 1;
                cs = 4'(1 << sel);
                if (c > TMO) begin
                    lat = TMO + 1; err = 1'b1; rd = wen ? model_rd : 32'h0;
                end else begin
                    lat = c + 1; err = 1'b0; rd = wen ? model_rd : sdata;
                end
            end
            model_rd = rd;
            run_and_check($sformatf("rnd%0d", n), addr, wdata, wen, d, sdata, lat, err, rd, cs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbus_interconnect.md
MBUS_INTERCONNECT -- requirements
Module: mbus_interconnect

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bus data/address width.
REQ-002 SHALL have parameter NSLAVE, default 4: number of slave channels, range 1..16.
REQ-003 SHALL have parameter SEL_LSB, default 12: lowest address bit of the 4-bit page field addr[SEL_LSB+3:SEL_LSB].
REQ-004 SHALL have parameter SLAVE_PAGE, default {4'hF,4'hE,4'hD,4'h0}: packed NSLAVE x 4-bit page per slave, slave i in bits [4i+3:4i].
REQ-005 SHALL have parameter WAIT_STATES, default all 4'd0: packed NSLAVE x 4-bit fixed wait count per slave.
REQ-006 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before error, range 2..255.
REQ-007 clk  input  1  bus clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 m_req  input  1  master transfer request, sampled in IDLE only.
REQ-010 m_addr  input  WIDTH  master address.
REQ-011 m_wdata  input  WIDTH  master write data.
REQ-012 m_wen  input  1  1 = write, 0 = read.
REQ-013 m_rdata  output  WIDTH  registered read data.
REQ-014 m_ready  output  1  one-cycle completion pulse.
REQ-015 m_err  output  1  one-cycle error pulse, coincident with m_ready.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 s_cs  output  NSLAVE  one-hot slave select.
REQ-018 s_addr, s_wdata  output  WIDTH each  latched address/write data.
REQ-019 s_wen  output  1  latched write enable, gated by any s_cs.
REQ-020 s_rdata  input  NSLAVE*WIDTH  slave read data, slave i in [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-021 s_ack  input  NSLAVE  slave completion; tied high by slaves without handshake.

Function
REQ-022 SHALL implement states IDLE, ACCESS, DONE, ERR.
REQ-023 IDLE with m_req=1: latch m_addr, m_wdata, m_wen; decode page; hit -> ACCESS, load wait counter from WAIT_STATES[sel], clear timeout counter; miss -> ERR.
REQ-024 Decode: slave i hits when page field equals SLAVE_PAGE[i]; multiple hits resolve to lowest index.
REQ-025 ACCESS: s_cs[sel]=1, s_wen=latched wen; wait counter decrements to 0 and holds.
REQ-026 ACCESS completes when wait counter==0 and s_ack[sel]=1: read captures s_rdata[sel] into m_rdata; write leaves m_rdata unchanged; -> DONE.
REQ-027 ACCESS with timeout counter == TIMEOUT-1 and not completing -> ERR; completion in that same cycle takes priority.
REQ-028 DONE: m_ready=1, m_err=0, s_cs=0 for one cycle -> IDLE.
REQ-029 ERR: m_ready=1, m_err=1, s_cs=0 for one cycle; read sets m_rdata=0; -> IDLE.
REQ-030 Latency: WAIT_STATES=0, s_ack high -> m_ready in cycle 2 after m_req sampled (cycle 0); each wait state adds one cycle.
REQ-031 m_req outside IDLE SHALL be ignored; a request held across DONE/ERR SHALL start a new transfer at the following IDLE cycle.
REQ-032 s_cs SHALL be one-hot or zero at all times; zero outside ACCESS.

Reset
REQ-033 reset low SHALL force IDLE, m_rdata=0, m_ready=0, m_err=0, busy=0, s_cs=0, s_wen=0, s_addr=0, s_wdata=0, counters=0, immediately and regardless of clk.
REQ-034 Reset mid-ACCESS SHALL abort with no m_ready pulse; first transfer after release behaves as from cold reset.

Structure
REQ-035 State encoding, page width (4), wait-count width (4) SHALL reside in package mbus_pkg.
REQ-036 Page decode SHALL be sub-module mbus_page_decoder (combinational, addr page -> one-hot hit + valid).

Verification
REQ-037 Read m_addr=0x0010, slave0 rdata=0xDEADBEEF, ws=0 -> s_cs=0001 cycle 1, m_ready, m_rdata=0xDEADBEEF cycle 2.
REQ-038 Write m_addr=0xF001, m_wdata=0x55 -> s_cs=1000, s_wen=1, s_addr=0xF001 one cycle; m_ready, m_err=0; m_rdata unchanged.
REQ-039 WAIT_STATES[1]=3, read 0xD000 -> m_ready in cycle 5.
REQ-040 Read page 0x7 (unmapped) -> s_cs stays 0, m_ready=m_err=1 cycle 1, m_rdata=0.
REQ-041 TIMEOUT=16, s_ack[2]=0 held -> ERR after 16 ACCESS cycles, m_err=1; s_ack rising same cycle -> normal DONE.
REQ-042 reset low during ACCESS -> all outputs 0 at once, no m_ready; next read completes in 2 cycles.
